// File: rtl/bpb_resolve_queue_pkg.sv
// Shared types and defaults for the branch-predictor resolve queue.
// `BPB_T (history-table index width) defaults here when the build does not set it.
`ifndef BPB_T
`define BPB_T 8
`endif

package bpb_resolve_queue_pkg;

  localparam int BPB_RQ_DEPTH_W = 2;

  // One in-flight prediction: table slot it came from and the direction guessed.
  typedef struct packed {
    logic [`BPB_T-1:0] index;
    logic              pred_taken;
  } bpb_resolve_entry_t;

endpackage

// File: rtl/bpb_resolve_queue_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module bpb_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  // Count events, holding once every bit is set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && !(&count_o)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bpb_resolve_queue.sv
// In-order queue of in-flight branch predictions. Fetch pushes {index, predicted
// direction}; execute resolves the oldest, which produces the history-table update
// triplet one cycle later and a mispredict pulse when the guess was wrong.
// A mispredict or flush discards every younger entry.
// Optional build macro BPB_RESOLVE_STATS_EN adds saturating resolve/mispredict counters.
module bpb_resolve_queue
  import bpb_resolve_queue_pkg::*;
#(
  parameter int DEPTH_WIDTH = BPB_RQ_DEPTH_W,
  parameter int INDEX_WIDTH = `BPB_T
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [INDEX_WIDTH-1:0] push_index_i,
  input  logic                   push_taken_i,
  output logic                   full_o,
  input  logic                   resolve_i,
  input  logic                   resolve_taken_i,
  output logic                   empty_o,
  input  logic                   flush_i,
  output logic                   upd_en_o,
  output logic                   upd_taken_o,
  output logic [INDEX_WIDTH-1:0] upd_index_o,
  output logic                   mispredict_o,
  output logic [DEPTH_WIDTH:0]   count_o
`ifdef BPB_RESOLVE_STATS_EN
  ,
  output logic [31:0]            resolved_cnt_o,
  output logic [31:0]            mispredict_cnt_o
`endif
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam int PTR_W = DEPTH_WIDTH + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_nxt, rd_ptr_nxt;
  bpb_resolve_entry_t mem_q [DEPTH];
  bpb_resolve_entry_t head;
  bpb_resolve_entry_t push_entry;
  logic               resolve_ok;
  logic               mispredict_now;
  logic               pop_this_cycle;
  logic               push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_WIDTH-1:0] == rd_ptr_q[DEPTH_WIDTH-1:0]) &&
                   (wr_ptr_q[DEPTH_WIDTH] != rd_ptr_q[DEPTH_WIDTH]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  assign head       = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
  assign push_entry = '{index: push_index_i, pred_taken: push_taken_i};

  // A resolve on an empty queue is meaningless and ignored. A mispredicting
  // resolve still retires the head but does not free a slot for a same-cycle
  // push, since that push is on the wrong path anyway.
  assign resolve_ok     = resolve_i && !empty_o;
  assign mispredict_now = resolve_ok && (resolve_taken_i != head.pred_taken);
  assign pop_this_cycle = resolve_ok && !mispredict_now;
  assign push_ok        = push_i && (!full_o || pop_this_cycle) &&
                          !flush_i && !mispredict_now;

  // Next pointers: flush or mispredict collapses the write pointer onto the
  // post-resolve read pointer, emptying the queue in one step.
  always_comb begin
    rd_ptr_nxt = rd_ptr_q + PTR_W'(resolve_ok);
    wr_ptr_nxt = wr_ptr_q + PTR_W'(push_ok);
    if (flush_i || mispredict_now) begin
      wr_ptr_nxt = rd_ptr_nxt;
    end
  end

  // Pointer and table-update registers; update outputs are one-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      upd_en_o     <= 1'b0;
      upd_taken_o  <= 1'b0;
      upd_index_o  <= '0;
      mispredict_o <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_nxt;
      rd_ptr_q     <= rd_ptr_nxt;
      upd_en_o     <= resolve_ok;
      mispredict_o <= mispredict_now;
      if (resolve_ok) begin
        upd_taken_o <= resolve_taken_i;
        upd_index_o <= head.index;
      end
    end
  end

  // Entry storage needs no reset: pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= push_entry;
    end
  end

`ifdef BPB_RESOLVE_STATS_EN
  bpb_sat_counter #(.WIDTH(32)) u_resolved_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (upd_en_o),
    .count_o (resolved_cnt_o)
  );

  bpb_sat_counter #(.WIDTH(32)) u_mispredict_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (mispredict_o),
    .count_o (mispredict_cnt_o)
  );
`endif

endmodule

// File: tb/tb_bpb_resolve_queue.sv
// Scoreboard bench for bpb_resolve_queue: the driver keeps a plain queue model of
// outstanding predictions and posts expected updates/occupancy; a monitor compares.
`ifndef BPB_T
`define BPB_T 8
`endif

module tb_bpb_resolve_queue;

  localparam int DW    = 2;
  localparam int IW    = `BPB_T;
  localparam int DEPTH = 4;
  localparam int unsigned IMASK = (1 << IW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          push_i = 1'b0;
  logic [IW-1:0] push_index_i = '0;
  logic          push_taken_i = 1'b0;
  logic          full_o;
  logic          resolve_i = 1'b0;
  logic          resolve_taken_i = 1'b0;
  logic          empty_o;
  logic          flush_i = 1'b0;
  logic          upd_en_o;
  logic          upd_taken_o;
  logic [IW-1:0] upd_index_o;
  logic          mispredict_o;
  logic [DW:0]   count_o;
`ifdef BPB_RESOLVE_STATS_EN
  logic [31:0]   resolved_cnt_o;
  logic [31:0]   mispredict_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  bpb_resolve_queue #(.DEPTH_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .push_i          (push_i),
    .push_index_i    (push_index_i),
    .push_taken_i    (push_taken_i),
    .full_o          (full_o),
    .resolve_i       (resolve_i),
    .resolve_taken_i (resolve_taken_i),
    .empty_o         (empty_o),
    .flush_i         (flush_i),
    .upd_en_o        (upd_en_o),
    .upd_taken_o     (upd_taken_o),
    .upd_index_o     (upd_index_o),
    .mispredict_o    (mispredict_o),
    .count_o         (count_o)
`ifdef BPB_RESOLVE_STATS_EN
    ,
    .resolved_cnt_o  (resolved_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
`endif
  );

  typedef struct {
    int unsigned idx;
    bit          pred;
  } ent_t;

  typedef struct {
    int unsigned idx;
    bit          taken;
    bit          mis;
  } upd_t;

  ent_t mq[$];     // outstanding predictions, oldest first
  upd_t exp_q[$];  // expected table updates
  int   st_q[$];   // expected occupancy after each edge

  int checks   = 0;
  int failures = 0;

  int unsigned m_res = 0, m_mis = 0;
  int unsigned h1_res = 0, h1_mis = 0, h2_res = 0, h2_mis = 0;
  bit          last_rst = 1'b1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus: drive inputs and advance the reference model.
  task automatic cyc(input bit rst, input bit push, input int unsigned idx,
                     input bit pt, input bit res, input bit rt, input bit fl);
    int   sz;
    bit   res_ok;
    bit   mis;
    ent_t e;
    upd_t u;
    @(negedge clk_i);
`ifdef BPB_RESOLVE_STATS_EN
    if (!last_rst) begin
      chk("resolved_cnt", longint'(resolved_cnt_o), longint'(h2_res));
      chk("mispredict_cnt", longint'(mispredict_cnt_o), longint'(h2_mis));
    end
`endif
    rst_i           = rst;
    push_i          = push;
    push_index_i    = IW'(idx);
    push_taken_i    = pt;
    resolve_i       = res;
    resolve_taken_i = rt;
    flush_i         = fl;
    if (rst) begin
      mq.delete();
      m_res = 0;
      m_mis = 0;
    end else begin
      sz     = mq.size();
      res_ok = res && (sz > 0);
      mis    = 1'b0;
      if (res_ok) begin
        mis     = (rt != mq[0].pred);
        u.idx   = mq[0].idx;
        u.taken = rt;
        u.mis   = mis;
        exp_q.push_back(u);
        void'(mq.pop_front());
        m_res++;
        if (mis) m_mis++;
      end
      if (fl || mis) begin
        mq.delete();
      end else if (push && (sz < DEPTH || res_ok)) begin
        e.idx  = idx & IMASK;
        e.pred = pt;
        mq.push_back(e);
      end
    end
    st_q.push_back(mq.size());
    h2_res = h1_res; h2_mis = h1_mis;
    h1_res = m_res;  h1_mis = m_mis;
    last_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: after every edge, compare occupancy and any update pulse.
  initial begin
    int   e;
    upd_t u;
    forever begin
      @(posedge clk_i);
      #2;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("count", longint'(count_o), longint'(e));
        chk("full", longint'(full_o), longint'(e == DEPTH));
        chk("empty", longint'(empty_o), longint'(e == 0));
      end
      if (upd_en_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_update", 1, 0);
        end else begin
          u = exp_q.pop_front();
          chk("upd_index", longint'(upd_index_o), longint'(u.idx));
          chk("upd_taken", longint'(upd_taken_o), longint'(u.taken));
          chk("mispredict", longint'(mispredict_o), longint'(u.mis));
        end
      end else begin
        chk("missing_update", longint'(exp_q.size()), 0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("mispredict_idle", longint'(mispredict_o), 0);
      end
    end
  end

  initial begin
    int unsigned idx;
    bit          pt, rt;
    // reset, push 5/T and 9/NT, resolve taken
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 1, 1, 0, 0);
    cyc(0, 1, 5, 1, 0, 0, 0);
    cyc(0, 1, 9, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // fill, overflow push dropped, drain in order
    for (int i = 1; i <= 4; i++) cyc(0, 1, i, 0, 0, 0, 0);
    cyc(0, 1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // full queue: push and correct resolve together
    for (int i = 1; i <= 4; i++) cyc(0, 1, i, 0, 0, 0, 0);
    cyc(0, 1, 8, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // mispredict discards younger entries and the same-cycle push
    cyc(0, 1, 3, 1, 0, 0, 0);
    cyc(0, 1, 6, 0, 0, 0, 0);
    cyc(0, 1, 10, 0, 0, 0, 0);
    cyc(0, 1, 11, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // flush with resolve of head 12, then resolve on empty
    cyc(0, 1, 12, 0, 0, 0, 0);
    cyc(0, 1, 13, 0, 0, 0, 0);
    cyc(0, 1, 14, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 1, 0);
    idle(1);

    // reset mid-operation: pending resolve leaves no update
    cyc(0, 1, 15, 1, 0, 0, 0);
    cyc(1, 1, 16, 0, 1, 1, 0);
    idle(2);

    // pointer wrap: 10 alternating push/resolve, every third one mispredicted
    for (int i = 0; i < 10; i++) begin
      pt = (i % 2) == 1;
      cyc(0, 1, 20 + i, pt, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, (i % 3 == 0) ? !pt : pt, 0);
    end
    idle(3);
`ifdef BPB_RESOLVE_STATS_EN
    chk("wrap_resolved_total", longint'(resolved_cnt_o), 10);
    chk("wrap_mispredict_total", longint'(mispredict_cnt_o), 4);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idx = $urandom_range(0, IMASK);
      pt  = 1'($urandom_range(0, 1));
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) rt = mq[0].pred;
      else rt = 1'($urandom_range(0, 1));
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, idx, pt,
          $urandom_range(0, 2) == 0, rt, $urandom_range(0, 19) == 0);
    end
    idle(3);
    @(negedge clk_i);
    chk("updates_drained", longint'(exp_q.size()), 0);
    chk("status_drained", longint'(st_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
